// File: rtl/proc512_sequencer.sv
// Command sequencer for the 512-bit processor datapath: turns LOAD/STORE/ADD/MUL
// commands into correctly timed register-file, memory and ALU control strobes.
module proc512_sequencer #(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned REG_LAT = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [1:0]       cmd_reg,
    input  logic [8:0]       cmd_addr,
    output logic [1:0]       reg_select,
    output logic [8:0]       mem_address,
    output logic             mem_to_reg_enable,
    output logic             mem_to_reg,
    output logic             ALU_Control,
    output logic             control,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [2:0] {
        IDLE,
        LD_WAIT,
        LD_WR,
        ALU_SETTLE,
        ALU_WR,
        ST_WR,
        FIN
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'd0;
    localparam logic [1:0] OP_STORE = 2'd1;
    localparam logic [1:0] OP_MUL   = 2'd3;
    localparam logic [8:0] ADDR_MAX = 9'd496;
    // Wait counters count down to zero, so a latency of N holds the state N cycles.
    localparam logic [7:0] MEM_WAIT = 8'(MEM_LAT - 1);
    localparam logic [7:0] REG_WAIT = 8'(REG_LAT - 1);

    state_t           r_state;
    logic [7:0]       r_wait;
    logic [1:0]       r_reg_select;
    logic [8:0]       r_mem_address;
    logic             r_mem_en;
    logic             r_mem_to_reg;
    logic             r_alu_wr;
    logic             r_control;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [CNT_W-1:0] r_op_count;

    logic             w_is_mem_op;
    logic             w_addr_bad;

    // A 16-word access starting above word 496 would run past word 511.
    assign w_is_mem_op = (cmd_op == OP_LOAD) || (cmd_op == OP_STORE);
    assign w_addr_bad  = w_is_mem_op && (cmd_addr > ADDR_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_wait        <= '0;
            r_reg_select  <= '0;
            r_mem_address <= '0;
            r_mem_en      <= 1'b0;
            r_mem_to_reg  <= 1'b0;
            r_alu_wr      <= 1'b0;
            r_control     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_op_count    <= '0;
        end else begin
            r_mem_en     <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_alu_wr     <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_busy <= 1'b1;
                        if (w_addr_bad) begin
                            r_state <= FIN;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (cmd_op == OP_LOAD) begin
                            r_mem_address <= cmd_addr;
                            r_reg_select  <= cmd_reg;
                            r_wait        <= MEM_WAIT;
                            r_state       <= LD_WAIT;
                        end else if (cmd_op == OP_STORE) begin
                            r_mem_address <= cmd_addr;
                            r_reg_select  <= cmd_reg;
                            r_mem_en      <= 1'b1;
                            r_state       <= ST_WR;
                        end else begin
                            r_control <= (cmd_op == OP_MUL);
                            r_wait    <= REG_WAIT;
                            r_state   <= ALU_SETTLE;
                        end
                    end
                end
                LD_WAIT: begin
                    if (r_wait == '0) begin
                        r_mem_en     <= 1'b1;
                        r_mem_to_reg <= 1'b1;
                        r_state      <= LD_WR;
                    end else begin
                        r_wait <= r_wait - 8'd1;
                    end
                end
                ALU_SETTLE: begin
                    if (r_wait == '0) begin
                        r_alu_wr <= 1'b1;
                        r_state  <= ALU_WR;
                    end else begin
                        r_wait <= r_wait - 8'd1;
                    end
                end
                LD_WR, ST_WR, ALU_WR: begin
                    r_done     <= 1'b1;
                    r_op_count <= r_op_count + CNT_W'(1);
                    r_state    <= FIN;
                end
                FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_ready         = (r_state == IDLE);
    assign reg_select        = r_reg_select;
    assign mem_address       = r_mem_address;
    assign mem_to_reg_enable = r_mem_en;
    assign mem_to_reg        = r_mem_to_reg;
    assign ALU_Control       = r_alu_wr;
    assign control           = r_control;
    assign busy              = r_busy;
    assign done              = r_done;
    assign err               = r_err;
    assign op_count          = r_op_count;

endmodule

// File: tb/tb_proc512_sequencer.sv
// Scoreboard bench for proc512_sequencer: the driver predicts each command's
// strobe/done timing and result, a negedge monitor compares what the DUT emits.
module tb_proc512_sequencer;

    localparam int unsigned MEM_LAT = 1;
    localparam int unsigned REG_LAT = 1;
    localparam int unsigned CNT_W   = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = '0;
    logic [1:0]       cmd_reg = '0;
    logic [8:0]       cmd_addr = '0;
    logic [1:0]       reg_select;
    logic [8:0]       mem_address;
    logic             mem_to_reg_enable;
    logic             mem_to_reg;
    logic             ALU_Control;
    logic             control;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] op_count;

    proc512_sequencer #(
        .MEM_LAT(MEM_LAT),
        .REG_LAT(REG_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_op           (cmd_op),
        .cmd_reg          (cmd_reg),
        .cmd_addr         (cmd_addr),
        .reg_select       (reg_select),
        .mem_address      (mem_address),
        .mem_to_reg_enable(mem_to_reg_enable),
        .mem_to_reg       (mem_to_reg),
        .ALU_Control      (ALU_Control),
        .control          (control),
        .busy             (busy),
        .done             (done),
        .err              (err),
        .op_count         (op_count)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = rejected (no strobe), 1 = memory strobe, 2 = ALU writeback strobe
    typedef struct {
        int unsigned      acc;
        int unsigned      kind;
        int unsigned      strobe_at;
        int unsigned      done_at;
        logic             err;
        logic [CNT_W-1:0] cnt;
        logic             m2r;
        logic [8:0]       addr;
        logic [1:0]       rg;
        logic             ctl;
    } exp_t;

    exp_t             exp_q[$];
    logic [CNT_W-1:0] exp_cnt = '0;
    int unsigned      prev_done = 0;
    int unsigned      n_vec = 0;
    int unsigned      n_cmp = 0;
    int unsigned      n_miss = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: gathers strobes and settles them against the next expected entry on done.
    int unsigned m_mem_n = 0, m_alu_n = 0, m_mem_at = 0, m_alu_at = 0;
    logic        m_m2r, m_ctl;
    logic [8:0]  m_addr;
    logic [1:0]  m_reg;

    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b0) begin
            chk("ready_vs_busy", {63'b0, cmd_ready}, {63'b0, ~busy});
            if (mem_to_reg_enable === 1'b1 || ALU_Control === 1'b1)
                chk("strobe_exclusive", {63'b0, mem_to_reg_enable & ALU_Control}, 64'd0);
            if (mem_to_reg_enable === 1'b1) begin
                m_mem_n++;
                m_mem_at = cyc;
                m_m2r    = mem_to_reg;
                m_addr   = mem_address;
                m_reg    = reg_select;
            end
            if (ALU_Control === 1'b1) begin
                m_alu_n++;
                m_alu_at = cyc;
                m_ctl    = control;
            end
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_done", {63'b0, done}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(e.done_at));
                    chk("err", {63'b0, err}, {63'b0, e.err});
                    chk("op_count", 64'(op_count), 64'(e.cnt));
                    chk("mem_strobe_count", 64'(m_mem_n), (e.kind == 1) ? 64'd1 : 64'd0);
                    chk("alu_strobe_count", 64'(m_alu_n), (e.kind == 2) ? 64'd1 : 64'd0);
                    if (e.kind == 1 && m_mem_n == 1) begin
                        chk("mem_strobe_cycle", 64'(m_mem_at), 64'(e.strobe_at));
                        chk("mem_to_reg", {63'b0, m_m2r}, {63'b0, e.m2r});
                        chk("mem_address", 64'(m_addr), 64'(e.addr));
                        chk("reg_select", 64'(m_reg), 64'(e.rg));
                    end
                    if (e.kind == 2 && m_alu_n == 1) begin
                        chk("alu_strobe_cycle", 64'(m_alu_at), 64'(e.strobe_at));
                        chk("control", {63'b0, m_ctl}, {63'b0, e.ctl});
                    end
                end
                m_mem_n = 0;
                m_alu_n = 0;
            end
        end
    end

    // Driver: called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [1:0] rg, input logic [8:0] ad,
                         input bit track, input bit b2b);
        exp_t        e;
        int unsigned guard = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_reg   = rg;
        cmd_addr  = ad;
        while (cmd_ready !== 1'b1 && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (cmd_ready !== 1'b1) begin
            chk("accept_timeout", {63'b0, cmd_ready}, 64'd1);
        end else begin
            e.acc  = cyc + 1;
            e.err  = (op <= 2'd1) && (ad > 9'd496);
            e.addr = ad;
            e.rg   = rg;
            e.ctl  = (op == 2'd3);
            e.m2r  = (op == 2'd0);
            if (e.err) begin
                e.kind      = 0;
                e.strobe_at = 0;
                e.done_at   = e.acc;
            end else if (op == 2'd0) begin
                e.kind      = 1;
                e.strobe_at = e.acc + MEM_LAT;
                e.done_at   = e.strobe_at + 1;
            end else if (op == 2'd1) begin
                e.kind      = 1;
                e.strobe_at = e.acc;
                e.done_at   = e.acc + 1;
            end else begin
                e.kind      = 2;
                e.strobe_at = e.acc + REG_LAT;
                e.done_at   = e.strobe_at + 1;
            end
            if (b2b) chk("b2b_accept_cycle", 64'(e.acc), 64'(prev_done + 2));
            if (track) begin
                if (!e.err) exp_cnt = exp_cnt + 1'b1;
                e.cnt = exp_cnt;
                exp_q.push_back(e);
                prev_done = e.done_at;
            end
            n_vec++;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int unsigned guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        chk(name, {busy, done, err, op_count, mem_to_reg_enable, mem_to_reg,
                   ALU_Control, reg_select, mem_address, control}, 64'd0);
        chk({name, "_ready"}, {63'b0, cmd_ready}, 64'd1);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, n_miss=%0d", n_miss);
        $fatal(1, "watchdog expired");
    end

    logic [1:0] d_op [9] = '{2'd0, 2'd0, 2'd2, 2'd3, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
    logic [1:0] d_rg [9] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd2, 2'd3, 2'd0, 2'd0, 2'd1};
    logic [8:0] d_ad [9] = '{9'h000, 9'h032, 9'h000, 9'h000, 9'h064,
                             9'h1F1, 9'h1FF, 9'h1F0, 9'h1F0};

    initial begin : driver
        logic [1:0] op, rg;
        logic [8:0] ad;
        bit         b;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("por_outputs");
        reset   = 1'b0;
        exp_cnt = '0;
        @(negedge clk);

        // Directed walk; the last four are presented with cmd_valid held high.
        for (int i = 0; i < 9; i++) begin
            if (i < 5) begin
                cmd_valid = 1'b0;
                @(negedge clk);
            end
            issue(d_op[i], d_rg[i], d_ad[i], 1'b1, i > 5);
        end
        cmd_valid = 1'b0;
        drain();

        // Reset lands while the LOAD sits in LD_WAIT; host keeps cmd_valid high.
        issue(2'd0, 2'd3, 9'h0A5, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midop_reset_outputs");
        reset   = 1'b0;
        exp_cnt = '0;
        issue(2'd1, 2'd2, 9'h010, 1'b1, 1'b0);
        cmd_valid = 1'b0;
        drain();

        for (int i = 0; i < 300; i++) begin
            op = 2'($urandom_range(0, 3));
            rg = 2'($urandom_range(0, 3));
            ad = ($urandom_range(0, 1) != 0) ? 9'($urandom_range(488, 511))
                                             : 9'($urandom_range(0, 511));
            b  = (i > 0) && ($urandom_range(0, 2) != 0);
            if (!b) begin
                cmd_valid = 1'b0;
                cmd_op    = 2'($urandom_range(0, 3));
                cmd_reg   = 2'($urandom_range(0, 3));
                cmd_addr  = 9'($urandom_range(0, 511));
                repeat ($urandom_range(0, 4)) @(negedge clk);
            end
            issue(op, rg, ad, 1'b1, b);
            // Scramble the command bus after accept; the DUT must ignore it.
            cmd_op   = 2'($urandom_range(0, 3));
            cmd_addr = 9'($urandom_range(0, 511));
        end
        cmd_valid = 1'b0;
        drain();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
